hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameters (name, default, meaning): MULT_CYC, 5, busy cycles after a mult/multu start.
REQ-002 SHALL provide parameter DIV_CYC, 10, busy cycles after a div/divu start.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports D_rs, D_rt  in  5 each  D-stage source register numbers.
REQ-006 SHALL have ports D_use_rs, D_use_rt  in  1 each  D-stage instruction reads rs / rt.
REQ-007 SHALL have ports D_Tuse_rs, D_Tuse_rt  in  3 each  cycles until D instruction needs rs / rt.
REQ-008 SHALL have port D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 SHALL have ports E_A3, M_A3  in  5 each  destination register of E / M instruction (0 = none).
REQ-010 SHALL have ports E_Tnew, M_Tnew  in  3 each  cycles until E / M result is available (M_Tnew already decremented by the E-to-M pipeline register).
REQ-011 SHALL have ports E_md_start  in  1  mult/div in E this cycle; E_md_div  in  1  1 = div, 0 = mult.
REQ-012 SHALL have outputs stall  1; F_En  1; D_En  1; E_clr  1; md_busy  1; stall_cnt  32  saturating stall-cycle count.

Function
REQ-013 rs_hz SHALL be 1 iff D_use_rs and D_rs!=0 and ((E_A3==D_rs and E_Tnew>D_Tuse_rs) or (M_A3==D_rs and M_Tnew>D_Tuse_rs)); rt_hz SHALL be defined the same way on rt.
REQ-014 md_hz SHALL be 1 iff D_is_md and (md_busy or E_md_start).
REQ-015 stall SHALL be the combinational OR of rs_hz, rt_hz and md_hz, with no registered latency.
REQ-016 F_En and D_En SHALL equal ~stall; E_clr SHALL equal stall, inserting a bubble into E; the E-to-M and M-to-W registers are never stalled.
REQ-017 Comparisons SHALL be unsigned 3-bit; Tnew==Tuse SHALL NOT stall, because that case is resolved by forwarding.
REQ-018 md_cnt (4-bit internal) SHALL be loaded on posedge when E_md_start and md_cnt==0, with MULT_CYC if E_md_div==0, else DIV_CYC.
REQ-019 Otherwise, md_cnt SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-020 md_busy SHALL equal (md_cnt!=0), a registered-state output.
REQ-021 E_md_start while md_cnt!=0 SHALL be ignored and SHALL NOT reload the counter; the stall logic prevents this case.
REQ-022 Simultaneous start and last busy cycle: when md_cnt==1 and E_md_start=1, the next md_cnt SHALL be 0, because the start is ignored.
REQ-023 stall_cnt SHALL increment by 1 on each posedge with stall=1 and SHALL saturate at 32'hFFFF_FFFF with no wrap.
REQ-024 Register 0 SHALL never cause a hazard, whatever its A3 or Tnew values.

Reset
REQ-025 On posedge with reset=1: md_cnt<=0, md_busy<=0 and stall_cnt<=0; reset SHALL take priority over E_md_start and over counting.
REQ-026 During the reset cycle, stall SHALL still be evaluated combinationally from its inputs, with md_busy read as the reset value on the following cycle.
REQ-027 Reset asserted mid-mult or mid-div SHALL abort the sequence: md_busy=0 on the next cycle.

Verification
REQ-028 Load-use: E_A3=8, E_Tnew=2, D_rs=8, D_use_rs=1, D_Tuse_rs=1 -> stall=1, F_En=D_En=0, E_clr=1; next cycle with E_A3=0, M_A3=8, M_Tnew=1 -> stall=0.
REQ-029 Forwardable case: E_A3=9, E_Tnew=1, D_rt=9, D_Tuse_rt=1 -> stall=0; same case with D_rt=0 or D_use_rt=0 -> stall=0.
REQ-030 Mult busy: E_md_start=1, E_md_div=0 for one cycle -> md_busy=1 for exactly 5 cycles; D_is_md=1 during that window -> stall=1; in the start cycle itself -> stall=1.
REQ-031 Div and ignored start: start a div -> md_busy=1 for 10 cycles; a second E_md_start at cycle 4 -> busy still ends after cycle 10.
REQ-032 Reset abort: reset=1 at cycle 3 of a div -> md_busy=0 and stall_cnt=0 the next cycle.
REQ-033 Saturation: force stall=1 with stall_cnt preset near 32'hFFFF_FFFE -> counter reaches and holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: Tuse/Tnew stall detection, multiply/divide busy
// tracking and a saturating count of stalled cycles.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic        D_use_rs,
  input  logic        D_use_rt,
  input  logic [2:0]  D_Tuse_rs,
  input  logic [2:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [2:0]  E_Tnew,
  input  logic [2:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        F_En,
  output logic        D_En,
  output logic        E_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        rs_hz, rt_hz, md_hz;

  // A producer only blocks us if its result lands strictly after we need it;
  // equal timing is covered by the forwarding paths.
  always_comb begin
    rs_hz = D_use_rs && (D_rs != 5'd0) &&
            (((E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
             ((M_A3 == D_rs) && (M_Tnew > D_Tuse_rs)));
    rt_hz = D_use_rt && (D_rt != 5'd0) &&
            (((E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
             ((M_A3 == D_rt) && (M_Tnew > D_Tuse_rt)));
    md_hz = D_is_md && (md_busy || E_md_start);
    stall = rs_hz || rt_hz || md_hz;
    F_En  = ~stall;
    D_En  = ~stall;
    E_clr = stall;
  end

  // NOTE: every variable in always_comb gets a default first so no latch is inferred.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (E_md_start) begin
      md_cnt_d = E_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = (md_cnt_q != 4'd0);
  assign stall_cnt = stall_cnt_q;

endmodule
